// File: rtl/alu_wb_arbiter_pkg.sv
// rtl/alu_wb_arbiter_pkg.sv - shared constants and helpers for the ALU writeback arbiter
package alu_wb_arbiter_pkg;

    localparam int DEF_NUM_ALU = 2;
    localparam int DEF_TAG_W   = 6;
    localparam int DEF_XLEN    = 32;
    localparam int DEF_DEPTH   = 4;

    // Default-width writeback record; the top re-declares it against its own parameters.
    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_XLEN-1:0]  data;
        logic                 mispred;
        logic [DEF_XLEN-1:0]  redirect_pc;
    } alu_wb_t;

    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_wb_arbiter_if.sv
// rtl/alu_wb_arbiter_if.sv - CDB writeback port (valid/ready plus payload)
interface alu_wb_arbiter_if #(
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
);
    logic             cdb_valid;
    logic             cdb_ready;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             cdb_mispred;
    logic [XLEN-1:0]  cdb_redirect_pc;

    modport master (
        output cdb_valid, cdb_tag, cdb_data, cdb_mispred, cdb_redirect_pc,
        input  cdb_ready
    );

    modport slave (
        input  cdb_valid, cdb_tag, cdb_data, cdb_mispred, cdb_redirect_pc,
        output cdb_ready
    );
endinterface

// File: rtl/alu_wb_arbiter_wb_fifo.sv
// rtl/alu_wb_arbiter_wb_fifo.sv - per-ALU sync FIFO with registered almost-full stall
module alu_wb_arbiter_wb_fifo
    import alu_wb_arbiter_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         stall_o
);
    localparam int AW = ptr_w(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]  count, count_d;
    logic         full, do_push, do_pop, stall_q;

    assign count   = wr_q - rd_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty_o = (wr_q == rd_q);
    assign do_pop  = pop_i && !empty_o && !flush_i;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push = push_i && !flush_i && (!full || do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    assign count_d = wr_d - rd_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            stall_q <= (count_d >= (AW+1)'(DEPTH-1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign stall_o = stall_q;
endmodule

// File: rtl/alu_wb_arbiter.sv
// rtl/alu_wb_arbiter.sv - buffers ALU writebacks onto one CDB port and picks the oldest mispredict
module alu_wb_arbiter
    import alu_wb_arbiter_pkg::*;
#(
    parameter int NUM_ALU = DEF_NUM_ALU,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int XLEN    = DEF_XLEN,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic [TAG_W-1:0]                rob_head_i,
    input  logic [NUM_ALU-1:0]              alu_valid_i,
    input  logic [NUM_ALU-1:0][TAG_W-1:0]   alu_rob_tag_i,
    input  logic [NUM_ALU-1:0][XLEN-1:0]    alu_result_i,
    input  logic [NUM_ALU-1:0]              alu_is_mispred_i,
    input  logic [NUM_ALU-1:0][XLEN-1:0]    alu_redirect_pc_i,
    output logic [NUM_ALU-1:0]              alu_stall_o,
    alu_wb_arbiter_if.master                cdb,
    output logic                            redirect_valid_o,
    output logic [TAG_W-1:0]                redirect_tag_o,
    output logic [XLEN-1:0]                 redirect_pc_o
);
    localparam int RR_W = ptr_w(NUM_ALU);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic             mispred;
        logic [XLEN-1:0]  redirect_pc;
    } wb_ent_t;

    wb_ent_t            push_ent [NUM_ALU];
    wb_ent_t            head_ent [NUM_ALU];
    wb_ent_t            head;
    logic [NUM_ALU-1:0] empty, pop;
    logic [RR_W-1:0]    rr_q, rr_d, grant;
    logic               any_ne, cdb_valid, fire;

    for (genvar k = 0; k < NUM_ALU; k++) begin : g_fifo
        assign push_ent[k] = '{tag: alu_rob_tag_i[k], data: alu_result_i[k],
                               mispred: alu_is_mispred_i[k], redirect_pc: alu_redirect_pc_i[k]};

        alu_wb_arbiter_wb_fifo #(.W($bits(wb_ent_t)), .DEPTH(DEPTH)) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (alu_valid_i[k]),
            .wdata_i (push_ent[k]),
            .pop_i   (pop[k]),
            .rdata_o (head_ent[k]),
            .empty_o (empty[k]),
            .stall_o (alu_stall_o[k])
        );
    end

    // Cyclic search for the first non-empty FIFO starting at rr_q.
    always_comb begin
        int idx;
        grant  = rr_q;
        any_ne = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_ALU; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_ALU) idx = idx - NUM_ALU;
            if (!any_ne && !empty[idx]) begin
                any_ne = 1'b1;
                grant  = RR_W'(idx);
            end
        end
    end

    assign head      = head_ent[grant];
    assign cdb_valid = any_ne && !flush_i;
    assign fire      = cdb_valid && cdb.cdb_ready;

    always_comb begin
        pop  = '0;
        rr_d = rr_q;
        for (int k = 0; k < NUM_ALU; k++) begin
            pop[k] = fire && (grant == RR_W'(k));
        end
        if (fire) rr_d = (grant == RR_W'(NUM_ALU-1)) ? '0 : grant + 1'b1;
    end

    assign cdb.cdb_valid       = cdb_valid;
    assign cdb.cdb_tag         = cdb_valid ? head.tag : '0;
    assign cdb.cdb_data        = cdb_valid ? head.data : '0;
    assign cdb.cdb_mispred     = cdb_valid && head.mispred;
    assign cdb.cdb_redirect_pc = cdb_valid ? head.redirect_pc : '0;

    logic             best_found;
    logic [RR_W-1:0]  best_idx;
    logic [TAG_W-1:0] best_age, age;
    logic             redir_valid_q;
    logic [TAG_W-1:0] redir_tag_q;
    logic [XLEN-1:0]  redir_pc_q;

    // Age relative to the ROB head wraps in TAG_W bits; strict compare keeps the lowest index on ties.
    always_comb begin
        best_found = 1'b0;
        best_idx   = '0;
        best_age   = '1;
        age        = '0;
        for (int i = 0; i < NUM_ALU; i++) begin
            age = alu_rob_tag_i[i] - rob_head_i;
            if (alu_valid_i[i] && alu_is_mispred_i[i] && (!best_found || age < best_age)) begin
                best_found = 1'b1;
                best_age   = age;
                best_idx   = RR_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q          <= '0;
            redir_valid_q <= 1'b0;
            redir_tag_q   <= '0;
            redir_pc_q    <= '0;
        end else begin
            rr_q          <= rr_d;
            redir_valid_q <= best_found && !flush_i;
            if (best_found && !flush_i) begin
                redir_tag_q <= alu_rob_tag_i[best_idx];
                redir_pc_q  <= alu_redirect_pc_i[best_idx];
            end
        end
    end

    assign redirect_valid_o = redir_valid_q;
    assign redirect_tag_o   = redir_tag_q;
    assign redirect_pc_o    = redir_pc_q;
endmodule

// File: tb/tb_alu_wb_arbiter.sv
// tb/tb_alu_wb_arbiter.sv - directed and table-driven checks for alu_wb_arbiter
module tb_alu_wb_arbiter;
    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [5:0]       head;
    logic [1:0]       alu_valid;
    logic [1:0][5:0]  alu_tag;
    logic [1:0][31:0] alu_res;
    logic [1:0]       alu_mis;
    logic [1:0][31:0] alu_pc;
    logic [1:0]       stall;
    logic             rv;
    logic [5:0]       rtag;
    logic [31:0]      rpc;

    int n_chk  = 0;
    int n_pass = 0;

    alu_wb_arbiter_if #(.TAG_W(6), .XLEN(32)) cdb_if ();

    alu_wb_arbiter #(.NUM_ALU(2), .TAG_W(6), .XLEN(32), .DEPTH(4)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .flush_i           (flush),
        .rob_head_i        (head),
        .alu_valid_i       (alu_valid),
        .alu_rob_tag_i     (alu_tag),
        .alu_result_i      (alu_res),
        .alu_is_mispred_i  (alu_mis),
        .alu_redirect_pc_i (alu_pc),
        .alu_stall_o       (stall),
        .cdb               (cdb_if.master),
        .redirect_valid_o  (rv),
        .redirect_tag_o    (rtag),
        .redirect_pc_o     (rpc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                assert (!(alu_valid[k] && stall[k]))
                    else $error("FAIL overflow_guard alu%0d pushed while stalled", k);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] dat(input logic [5:0] t);
        return 32'hD000_0000 | {26'd0, t};
    endfunction

    task automatic idle();
        alu_valid = 2'b00;
        alu_mis   = 2'b00;
        flush     = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  v, m;
        logic [5:0]  t0, t1, hd;
        logic [31:0] pc0, pc1;
        logic        ev;
        logic [5:0]  etag;
        logic [31:0] epc;
    } redir_vec_t;

    redir_vec_t vt [9];

    int          q0[$], q1[$];
    int          rr_m, g, n0, n1, etag_i;
    logic        ev;

    initial begin
        vt[0] = '{2'b11, 2'b11, 6'd10, 6'd3,  6'd60, 32'hA000_0000, 32'hB000_0000, 1'b1, 6'd3,  32'hB000_0000};
        vt[1] = '{2'b11, 2'b11, 6'd10, 6'd3,  6'd2,  32'hA000_0010, 32'hB000_0010, 1'b1, 6'd3,  32'hB000_0010};
        vt[2] = '{2'b11, 2'b11, 6'd5,  6'd5,  6'd0,  32'hA000_0020, 32'hB000_0020, 1'b1, 6'd5,  32'hA000_0020};
        vt[3] = '{2'b01, 2'b11, 6'd20, 6'd9,  6'd30, 32'hA000_0030, 32'hB000_0030, 1'b1, 6'd20, 32'hA000_0030};
        vt[4] = '{2'b11, 2'b00, 6'd1,  6'd2,  6'd0,  32'hA000_0040, 32'hB000_0040, 1'b0, 6'd20, 32'hA000_0030};
        vt[5] = '{2'b11, 2'b11, 6'd63, 6'd1,  6'd62, 32'hA000_0050, 32'hB000_0050, 1'b1, 6'd63, 32'hA000_0050};
        vt[6] = '{2'b11, 2'b10, 6'd4,  6'd7,  6'd0,  32'hA000_0060, 32'hB000_0060, 1'b1, 6'd7,  32'hB000_0060};
        vt[7] = '{2'b11, 2'b01, 6'd39, 6'd41, 6'd40, 32'hA000_0070, 32'hB000_0070, 1'b1, 6'd39, 32'hA000_0070};
        vt[8] = '{2'b11, 2'b11, 6'd50, 6'd45, 6'd48, 32'hA000_0080, 32'hB000_0080, 1'b1, 6'd50, 32'hA000_0080};

        rst_n = 1'b0; idle(); head = '0; alu_tag = '0; alu_res = '0; alu_pc = '0;
        cdb_if.cdb_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_cdb_valid", cdb_if.cdb_valid, 0);
        chk("reset_cdb_tag", cdb_if.cdb_tag, 0);
        chk("reset_cdb_data", cdb_if.cdb_data, 0);
        chk("reset_redirect", {rv, rtag, rpc}, 0);
        chk("reset_stall", stall, 0);
        rst_n = 1'b1;

        // Single push on ALU0
        @(negedge clk);
        cdb_if.cdb_ready = 1'b1;
        alu_valid = 2'b01; alu_tag[0] = 6'd5; alu_res[0] = 32'h1234;
        @(negedge clk);
        chk("single_valid", cdb_if.cdb_valid, 1);
        chk("single_tag", cdb_if.cdb_tag, 5);
        chk("single_data", cdb_if.cdb_data, 32'h1234);
        idle();
        @(negedge clk);
        chk("single_drained", cdb_if.cdb_valid, 0);

        // Backpressure hold: rr now points at ALU1
        cdb_if.cdb_ready = 1'b0;
        alu_valid = 2'b11; alu_tag[0] = 6'd1; alu_res[0] = dat(6'd1); alu_tag[1] = 6'd40; alu_res[1] = dat(6'd40);
        @(negedge clk);
        alu_valid = 2'b01; alu_tag[0] = 6'd2; alu_res[0] = dat(6'd2);
        @(negedge clk);
        alu_tag[0] = 6'd3; alu_res[0] = dat(6'd3);
        @(negedge clk);
        idle();
        chk("hold_stall", stall, 2'b01);
        for (int i = 0; i < 5; i++) begin
            chk("hold_cdb_stable", {cdb_if.cdb_valid, cdb_if.cdb_tag, cdb_if.cdb_data}, {1'b1, 6'd40, dat(6'd40)});
            @(negedge clk);
        end
        cdb_if.cdb_ready = 1'b1;
        chk("order_0", cdb_if.cdb_tag, 40);
        @(negedge clk);
        chk("order_1", cdb_if.cdb_tag, 1);
        @(negedge clk);
        chk("order_2", cdb_if.cdb_tag, 2);
        chk("stall_release", stall, 2'b00);
        @(negedge clk);
        chk("order_3", cdb_if.cdb_tag, 3);
        @(negedge clk);
        chk("order_empty", cdb_if.cdb_valid, 0);

        // Redirect table
        for (int r = 0; r < 9; r++) begin
            alu_valid = vt[r].v; alu_mis = vt[r].m; head = vt[r].hd;
            alu_tag[0] = vt[r].t0; alu_tag[1] = vt[r].t1;
            alu_res[0] = dat(vt[r].t0); alu_res[1] = dat(vt[r].t1);
            alu_pc[0] = vt[r].pc0; alu_pc[1] = vt[r].pc1;
            @(negedge clk);
            chk($sformatf("redir_valid_row%0d", r), rv, vt[r].ev);
            chk($sformatf("redir_tag_row%0d", r), rtag, vt[r].etag);
            chk($sformatf("redir_pc_row%0d", r), rpc, vt[r].epc);
            idle();
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("table_drained", cdb_if.cdb_valid, 0);

        // Flush with buffered entries and a concurrent mispredict
        cdb_if.cdb_ready = 1'b0; head = 6'd0;
        alu_valid = 2'b11; alu_tag[0] = 6'd11; alu_tag[1] = 6'd12;
        @(negedge clk);
        alu_valid = 2'b01; alu_tag[0] = 6'd13;
        @(negedge clk);
        idle();
        chk("flush_pre_valid", cdb_if.cdb_valid, 1);
        @(negedge clk);
        flush = 1'b1; alu_valid = 2'b11; alu_mis = 2'b11; alu_tag[0] = 6'd14; alu_tag[1] = 6'd15;
        #1;
        chk("flush_cycle_valid", cdb_if.cdb_valid, 0);
        @(negedge clk);
        idle();
        chk("flush_after_valid", cdb_if.cdb_valid, 0);
        chk("flush_after_redirect", rv, 0);
        chk("flush_after_stall", stall, 0);
        cdb_if.cdb_ready = 1'b1;
        @(negedge clk);
        chk("flush_inputs_dropped", cdb_if.cdb_valid, 0);

        // Asynchronous reset mid-stream
        cdb_if.cdb_ready = 1'b0;
        alu_valid = 2'b01; alu_mis = 2'b01; alu_tag[0] = 6'd21; alu_res[0] = dat(6'd21); alu_pc[0] = 32'hC000_0000;
        @(negedge clk);
        idle();
        chk("prereset_active", {rv, cdb_if.cdb_valid}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_cdb", {cdb_if.cdb_valid, cdb_if.cdb_tag, cdb_if.cdb_data, cdb_if.cdb_mispred}, 0);
        chk("async_reset_cdb_pc", cdb_if.cdb_redirect_pc, 0);
        chk("async_reset_redirect", {rv, rtag, rpc}, 0);
        chk("async_reset_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1; cdb_if.cdb_ready = 1'b1;
        @(negedge clk);
        alu_valid = 2'b01; alu_tag[0] = 6'd22; alu_res[0] = dat(6'd22);
        #1;
        chk("post_reset_no_bypass", cdb_if.cdb_valid, 0);
        @(negedge clk);
        idle();
        chk("post_reset_first", {cdb_if.cdb_valid, cdb_if.cdb_tag, cdb_if.cdb_data}, {1'b1, 6'd22, dat(6'd22)});
        @(negedge clk);
        chk("post_reset_drained", cdb_if.cdb_valid, 0);

        // Both ALUs streaming with ready toggling, checked against a round-robin model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_m = 0; n0 = 0; n1 = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            ev = (q0.size() > 0) || (q1.size() > 0);
            chk("stream_valid", cdb_if.cdb_valid, ev);
            g = rr_m;
            if (ev) begin
                if ((g == 0) ? (q0.size() == 0) : (q1.size() == 0)) g = 1 - g;
                etag_i = (g == 0) ? q0[0] : q1[0];
                chk("stream_tag", cdb_if.cdb_tag, etag_i);
                chk("stream_data", cdb_if.cdb_data, dat(6'(etag_i)));
            end
            chk("stream_stall", stall, {q1.size() >= 3, q0.size() >= 3});
            cdb_if.cdb_ready = (cyc % 2 == 0);
            if (ev && cdb_if.cdb_ready) begin
                if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                rr_m = 1 - g;
            end
            alu_valid = 2'b00;
            if (cyc < 24) begin
                if (!stall[0]) begin
                    alu_valid[0] = 1'b1; alu_tag[0] = 6'(n0); alu_res[0] = dat(6'(n0));
                    q0.push_back(n0); n0++;
                end
                if (!stall[1]) begin
                    alu_valid[1] = 1'b1; alu_tag[1] = 6'(32 + n1); alu_res[1] = dat(6'(32 + n1));
                    q1.push_back(32 + n1); n1++;
                end
            end
            @(negedge clk);
        end
        idle();
        chk("stream_all_delivered", {cdb_if.cdb_valid, q0.size() == 0, q1.size() == 0}, 3'b011);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
